pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset: ports clk and reset.
REQ-002 WIDTH, default 64, SHALL set the address width in bits.
REQ-003 RESET_VECTOR, default 0, SHALL set the address loaded by reset.
REQ-004 STEP, default 4, SHALL set the sequential increment in bytes.
REQ-005 RAS_DEPTH, default 4, SHALL set the return-address-stack entry count, a power of two ≥2.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 stall  in  1  holds all state when high.
REQ-009 br_taken  in  1  redirects to br_target.
REQ-010 br_target  in  WIDTH  redirect address.
REQ-011 call  in  1  pushes the return address pc+STEP.
REQ-012 ret  in  1  redirects to the popped return address.
REQ-013 pc  out  WIDTH  current fetch address, registered.
REQ-014 valid  out  1  pc is a fetchable address this cycle.
REQ-015 trap  out  1  a misaligned redirect occurred; sticky.
REQ-016 ras_empty, ras_full  out  1 each  stack status, registered.

Function
REQ-017 The state machine SHALL have three states: BOOT, RUN and TRAP.
- BOOT→RUN on the first rising edge after reset deasserts, regardless of stall.
REQ-018 valid SHALL be 1 only in RUN.
- trap SHALL be 1 only in TRAP.
REQ-019 In RUN with stall=1, pc, the stack and the state SHALL hold.
- br_taken, call and ret SHALL be ignored that cycle.
REQ-020 In RUN with stall=0, the next pc SHALL be chosen in this priority order:
- ret with a non-empty stack → popped top;
- ret with an empty stack, or br_taken → br_target;
- otherwise → pc+STEP.
REQ-021 Address arithmetic SHALL wrap modulo 2^WIDTH: all-ones minus STEP-1 plus STEP gives 0, with no flag.
REQ-022 A redirect target with bits[1:0]≠0 SHALL cause the following:
- pc is not updated;
- any pop or push in that cycle is cancelled;
- the state becomes TRAP.
REQ-023 TRAP SHALL hold pc and the stack, ignore all inputs and exit only through reset.
REQ-024 call in an advancing RUN cycle SHALL push the old pc+STEP.
REQ-025 call with a full stack SHALL overwrite the oldest entry (circular).
- ras_full stays 1 in that case.
REQ-026 call and ret together SHALL pop first, then push.
- The net effect replaces the top entry.
- Depth is unchanged; ret with an empty stack still pushes.
REQ-027 ras_empty and ras_full SHALL reflect the entry count after each clock edge.

Reset
REQ-028 While reset=1, the outputs SHALL be:
- pc=RESET_VECTOR;
- state BOOT, valid=0, trap=0;
- stack count 0, ras_empty=1, ras_full=0.
REQ-029 Reset asserted mid-operation, including in TRAP, SHALL take effect immediately without waiting for clk.
- Stack contents are discarded.

Configuration
REQ-030 Macro PC_UNIT_RAS_EN SHALL compile the return-address stack in.
REQ-031 With PC_UNIT_RAS_EN undefined, the following SHALL apply:
- no stack storage exists;
- call is ignored;
- ret behaves as br_taken;
- ras_empty is tied to 1 and ras_full to 0.

Verification
REQ-032 The bench SHALL cover these directed scenarios, with WIDTH=64, STEP=4, RESET_VECTOR=0x100:
- Release reset with no other inputs → valid=0 for one cycle, then pc 0x100, 0x104, 0x108 with valid=1.
- stall=1 for 3 cycles with br_taken=1 at pc=0x108 → pc holds 0x108; after release, pc=0x10C.
- br_taken=1 with br_target=0x2002 → pc holds and trap=1 from the next cycle; pulsing reset → pc=0x100, trap=0.
- call at pc=0x200 with target 0x400, then ret → pc=0x400, then 0x204; ras_empty returns to 1.
- RAS_DEPTH=4 with 5 nested calls, then 5 rets → the first 4 rets return correctly, ras_full=1 after call 4; the 5th ret goes to br_target.
- pc=0xFFFF_FFFF_FFFF_FFFC advancing → pc=0; call+ret in the same cycle → stack depth unchanged, top=old pc+4.

Source files
------------

// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Fetch program counter with branch redirect, misalignment trap and
//            an optional return-address stack, built in by PC_UNIT_RAS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int               WIDTH        = 64,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STEP         = 4,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_target,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] pc,
    output logic             valid,
    output logic             trap,
    output logic             ras_empty,
    output logic             ras_full
);

    localparam logic [WIDTH-1:0] c_step = WIDTH'(STEP);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_TRAP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_seq_pc;
    logic [WIDTH-1:0] w_target;
    logic [WIDTH-1:0] w_ras_top;
    logic             w_ras_hit;
    logic             w_redirect;
    logic             w_active;
    logic             w_misalign;
    logic             w_adv;

    assign w_seq_pc   = r_pc + c_step;
    // A popped return address takes precedence over br_target; an empty stack
    // makes ret fall through to br_target.
    assign w_redirect = ret | br_taken;
    assign w_target   = w_ras_hit ? w_ras_top : br_target;
    assign w_active   = (r_state == S_RUN) && !stall;
    assign w_misalign = w_active && w_redirect && (w_target[1:0] != 2'b00);
    assign w_adv      = w_active && !w_misalign;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            S_BOOT: w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_misalign) begin
                    w_state_nxt = S_TRAP;
                end else if (w_adv) begin
                    w_pc_nxt = w_redirect ? w_target : w_seq_pc;
                end
            end
            S_TRAP: w_state_nxt = S_TRAP;
            default: w_state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign pc    = r_pc;
    assign valid = (r_state == S_RUN);
    assign trap  = (r_state == S_TRAP);

`ifdef PC_UNIT_RAS_EN
    localparam int             c_aw    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [c_aw:0]  c_depth = (c_aw + 1)'(RAS_DEPTH);

    logic [WIDTH-1:0] r_ras_mem [RAS_DEPTH];
    logic [c_aw-1:0]  r_ras_top;
    logic [c_aw-1:0]  w_ras_top_nxt;
    logic [c_aw:0]    r_ras_cnt;
    logic [c_aw:0]    w_ras_cnt_nxt;
    logic             r_ras_empty;
    logic             r_ras_full;
    logic             w_pop;
    logic             w_push;

    assign w_ras_hit = ret && (r_ras_cnt != '0);
    assign w_ras_top = r_ras_mem[r_ras_top];
    assign w_pop     = w_adv && w_ras_hit;
    assign w_push    = w_adv && call;

    // Pop+push keeps the pointer and overwrites the top; a push onto a full
    // stack advances the pointer over the oldest entry without growing.
    always_comb begin
        w_ras_top_nxt = r_ras_top;
        w_ras_cnt_nxt = r_ras_cnt;
        if (w_pop && !w_push) begin
            w_ras_top_nxt = r_ras_top - 1'b1;
            w_ras_cnt_nxt = r_ras_cnt - 1'b1;
        end else if (w_push && !w_pop) begin
            w_ras_top_nxt = r_ras_top + 1'b1;
            if (r_ras_cnt != c_depth) begin
                w_ras_cnt_nxt = r_ras_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ras_top   <= '0;
            r_ras_cnt   <= '0;
            r_ras_empty <= 1'b1;
            r_ras_full  <= 1'b0;
        end else begin
            r_ras_top   <= w_ras_top_nxt;
            r_ras_cnt   <= w_ras_cnt_nxt;
            r_ras_empty <= (w_ras_cnt_nxt == '0);
            r_ras_full  <= (w_ras_cnt_nxt == c_depth);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras_mem[w_ras_top_nxt] <= w_seq_pc;
        end
    end

    assign ras_empty = r_ras_empty;
    assign ras_full  = r_ras_full;
`else
    localparam int c_unused_depth = RAS_DEPTH;

    logic w_unused;

    assign w_unused  = call;
    assign w_ras_hit = 1'b0;
    assign w_ras_top = br_target;
    assign ras_empty = 1'b1;
    assign ras_full  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pc_unit
// Brief    : Directed vector bench for pc_unit; expectations follow whether
//            PC_UNIT_RAS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

`ifdef PC_UNIT_RAS_EN
    localparam bit c_ras = 1'b1;
`else
    localparam bit c_ras = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        stall;
    logic        br_taken;
    logic [63:0] br_target;
    logic        call;
    logic        ret;
    logic [63:0] pc;
    logic        valid;
    logic        trap;
    logic        ras_empty;
    logic        ras_full;

    int n_pass  = 0;
    int n_total = 0;

    pc_unit #(
        .WIDTH       (64),
        .RESET_VECTOR(64'h100),
        .STEP        (4),
        .RAS_DEPTH   (4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .br_taken (br_taken),
        .br_target(br_target),
        .call     (call),
        .ret      (ret),
        .pc       (pc),
        .valid    (valid),
        .trap     (trap),
        .ras_empty(ras_empty),
        .ras_full (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic        cl;
        logic        rt;
        logic [63:0] tgt;
        logic [63:0] pc_ras;
        logic [63:0] pc_bare;
        logic        e_ras;
        logic        f_ras;
        logic        tr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic br, input logic cl,
                                input logic rt, input logic [63:0] tgt,
                                input logic [63:0] pr, input logic [63:0] pb,
                                input logic e, input logic f, input logic tr);
        vec_t v;
        v.st = st; v.br = br; v.cl = cl; v.rt = rt; v.tgt = tgt;
        v.pc_ras = pr; v.pc_bare = pb; v.e_ras = e; v.f_ras = f; v.tr = tr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [63:0] e_pc, input logic e_valid,
                           input logic e_trap, input logic e_empty, input logic e_full);
        chk({tag, ".pc"},    pc,        e_pc);
        chk({tag, ".valid"}, 64'(valid),     64'(e_valid));
        chk({tag, ".trap"},  64'(trap),      64'(e_trap));
        chk({tag, ".empty"}, 64'(ras_empty), 64'(e_empty));
        chk({tag, ".full"},  64'(ras_full),  64'(e_full));
    endtask

    task automatic drive(input logic st, input logic br, input logic [63:0] tgt,
                         input logic cl, input logic rt);
        stall = st; br_taken = br; br_target = tgt; call = cl; ret = rt;
    endtask

    initial begin
        // stall br call ret target | pc(RAS) pc(no RAS) empty(RAS) full(RAS) trap
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h100,  64'h100,  1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h104,  64'h104,  1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h108,  64'h108,  1,0,0));
        vecs.push_back(mk(1,1,0,0, 64'h3000, 64'h108,  64'h108,  1,0,0));
        vecs.push_back(mk(1,1,0,0, 64'h3000, 64'h108,  64'h108,  1,0,0));
        vecs.push_back(mk(1,1,0,0, 64'h3000, 64'h108,  64'h108,  1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h10C,  64'h10C,  1,0,0));
        vecs.push_back(mk(0,1,0,0, 64'h200,  64'h200,  64'h200,  1,0,0));
        vecs.push_back(mk(0,1,1,0, 64'h400,  64'h400,  64'h400,  0,0,0));
        vecs.push_back(mk(0,0,0,1, 64'h600,  64'h204,  64'h600,  1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h208,  64'h604,  1,0,0));
        vecs.push_back(mk(0,1,0,0, 64'h1000, 64'h1000, 64'h1000, 1,0,0));
        vecs.push_back(mk(0,1,1,0, 64'h2000, 64'h2000, 64'h2000, 0,0,0));
        vecs.push_back(mk(0,1,1,0, 64'h3000, 64'h3000, 64'h3000, 0,0,0));
        vecs.push_back(mk(0,1,1,0, 64'h4000, 64'h4000, 64'h4000, 0,0,0));
        vecs.push_back(mk(0,1,1,0, 64'h5000, 64'h5000, 64'h5000, 0,1,0));
        vecs.push_back(mk(0,1,1,0, 64'h6000, 64'h6000, 64'h6000, 0,1,0));
        vecs.push_back(mk(0,0,0,1, 64'hA000, 64'h5004, 64'hA000, 0,0,0));
        vecs.push_back(mk(0,0,0,1, 64'hA000, 64'h4004, 64'hA000, 0,0,0));
        vecs.push_back(mk(0,0,0,1, 64'hA000, 64'h3004, 64'hA000, 0,0,0));
        vecs.push_back(mk(0,0,0,1, 64'hA000, 64'h2004, 64'hA000, 1,0,0));
        vecs.push_back(mk(0,0,0,1, 64'hA000, 64'hA000, 64'hA000, 1,0,0));
        vecs.push_back(mk(0,1,1,0, 64'hB000, 64'hB000, 64'hB000, 0,0,0));
        vecs.push_back(mk(0,0,1,1, 64'hC000, 64'hA004, 64'hC000, 0,0,0));
        vecs.push_back(mk(0,0,0,1, 64'hD000, 64'hB004, 64'hD000, 1,0,0));
        vecs.push_back(mk(0,0,1,1, 64'hE000, 64'hE000, 64'hE000, 0,0,0));
        vecs.push_back(mk(0,0,0,1, 64'hF000, 64'hB008, 64'hF000, 1,0,0));
        vecs.push_back(mk(0,1,0,0, 64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC,
                          64'hFFFF_FFFF_FFFF_FFFC, 1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h0,    64'h0,    1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h4,    64'h4,    1,0,0));
        vecs.push_back(mk(1,0,1,1, 64'h8000, 64'h4,    64'h4,    1,0,0));
        vecs.push_back(mk(0,0,0,0, 64'h0,    64'h8,    64'h8,    1,0,0));
        // Misaligned redirect with call: pc holds, push cancelled, then TRAP.
        vecs.push_back(mk(0,1,1,0, 64'h2002, 64'h8,    64'h8,    1,0,1));
        vecs.push_back(mk(0,1,0,0, 64'h3000, 64'h8,    64'h8,    1,0,1));
        vecs.push_back(mk(0,0,1,1, 64'h3000, 64'h8,    64'h8,    1,0,1));

        reset = 1'b1;
        drive(0, 0, 64'h0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 64'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk_all("boot", 64'h100, 1'b0, 1'b0, 1'b1, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].tgt, vecs[i].cl, vecs[i].rt);
            @(posedge clk);
            #1;
            chk_all($sformatf("v%0d", i),
                    c_ras ? vecs[i].pc_ras : vecs[i].pc_bare,
                    !vecs[i].tr, vecs[i].tr,
                    c_ras ? vecs[i].e_ras : 1'b1,
                    c_ras ? vecs[i].f_ras : 1'b0);
        end

        // Asynchronous reset from TRAP takes effect before the next clock edge.
        drive(0, 0, 64'h0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_all("arst_trap", 64'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk_all("boot2", 64'h100, 1'b0, 1'b0, 1'b1, 1'b0);

        // BOOT leaves for RUN even while stalled; stall then holds pc.
        stall = 1'b1;
        @(posedge clk);
        #1;
        chk_all("boot_stall", 64'h100, 1'b1, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        chk_all("run_stall", 64'h100, 1'b1, 1'b0, 1'b1, 1'b0);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk_all("run_adv", 64'h104, 1'b1, 1'b0, 1'b1, 1'b0);

        // Reset while the stack holds an entry discards it immediately.
        drive(0, 1, 64'h400, 1, 0);
        @(posedge clk);
        #1;
        chk_all("push1", 64'h400, 1'b1, 1'b0, !c_ras, 1'b0);
        drive(0, 0, 64'h0, 0, 0);
        #2 reset = 1'b1;
        #1;
        chk_all("arst_ras", 64'h100, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        drive(0, 0, 64'h800, 0, 1);
        @(posedge clk);
        #1;
        chk_all("ret_after_rst", 64'h800, 1'b1, 1'b0, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
